// File: rtl/debouncer_pkg.sv
// debouncer_pkg: shared state type and default constants for the N-channel debouncer
package debouncer_pkg;
    typedef enum logic {ST_STABLE, ST_CHANGING} deb_state_t;
    localparam int DEB_CLK_HZ     = 10_000_000;
    localparam int DEB_TICK_HZ    = 1_000;
    localparam int DEB_STABLE_CNT = 8;
endpackage

// File: rtl/module_debounce_ch.sv
// module_debounce_ch: one debounce channel (stability FSM, tick counter, rise/fall pulse registers)
module module_debounce_ch
    import debouncer_pkg::*;
#(
    parameter int STABLE_CNT = DEB_STABLE_CNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic s,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(STABLE_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    deb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (tick) begin
            // A sample matching the current level aborts any count in progress
            if (s == level_q) begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end else if (state_q == ST_STABLE) begin
                state_d = ST_CHANGING;
                cnt_d   = CW'(1);
            end else if (cnt_q == CNT_LAST) begin
                state_d = ST_STABLE;
                cnt_d   = '0;
                level_d = s;
                rise_d  = s;
                fall_d  = !s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
endmodule

// File: rtl/module_debouncer_nch.sv
// module_debouncer_nch: N-channel button debouncer with shared sample-tick prescaler.
// Define DEBOUNCER_SYNC_EN to pass each bt_in bit through a two-flop synchroniser.
module module_debouncer_nch
    import debouncer_pkg::*;
#(
    parameter int CLK_HZ     = DEB_CLK_HZ,
    parameter int TICK_HZ    = DEB_TICK_HZ,
    parameter int N_CH       = 4,
    parameter int STABLE_CNT = DEB_STABLE_CNT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] bt_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            any_level
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    if (DIV < 2) begin : g_div_chk
        $error("module_debouncer_nch: CLK_HZ/TICK_HZ must be >= 2");
    end
    if (N_CH < 1) begin : g_nch_chk
        $error("module_debouncer_nch: N_CH must be >= 1");
    end
    if (STABLE_CNT < 2) begin : g_cnt_chk
        $error("module_debouncer_nch: STABLE_CNT must be >= 2");
    end

    logic [PW-1:0]   pre_q, pre_d;
    logic            tick;
    logic            any_level_q, any_level_d;
    logic [N_CH-1:0] s;

    always_comb begin
        tick        = (pre_q == PRE_LAST);
        pre_d       = tick ? '0 : pre_q + 1'b1;
        any_level_d = |level;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q       <= '0;
            any_level_q <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            any_level_q <= any_level_d;
        end
    end

`ifdef DEBOUNCER_SYNC_EN
    logic [N_CH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bt_in;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = bt_in;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        module_debounce_ch #(
            .STABLE_CNT(STABLE_CNT)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .s    (s[i]),
            .level(level[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    assign any_level = any_level_q;
endmodule

// File: tb/tb_module_debouncer_nch.sv
// tb_module_debouncer_nch: scenario tasks for the debouncer; expected pulses are queued at
// stimulus time and matched by a monitor as the DUT emits them.
module tb_module_debouncer_nch;
    localparam int LO = 9;
    localparam int HI = 12;
`ifdef DEBOUNCER_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    typedef struct {
        int ch;
        bit is_rise;
        int lo;
        int hi;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] bt_in = 4'hF;
    logic [3:0] level, rise, fall;
    logic       any_level;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   fall_cyc[4];

    module_debouncer_nch #(
        .CLK_HZ(1000),
        .TICK_HZ(250),
        .N_CH(4),
        .STABLE_CNT(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bt_in(bt_in),
        .level(level),
        .rise(rise),
        .fall(fall),
        .any_level(any_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin : mon
        exp_t e;
        cyc++;
        #1;
        for (int ch = 0; ch < 4; ch++) begin
            if (rise[ch] || fall[ch]) begin
                if (fall[ch]) fall_cyc[ch] = cyc;
                n_cmp++;
                if (rise[ch] && fall[ch]) begin
                    n_err++;
                    $display("FAIL pulse_excl ch%0d: rise=1 fall=1 at cycle %0d, required at most one", ch, cyc);
                end else if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL pulse_unexpected ch%0d: rise=%0b fall=%0b at cycle %0d, required none", ch, rise[ch], fall[ch], cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.ch != ch || e.is_rise != rise[ch] || cyc < e.lo || cyc > e.hi) begin
                        n_err++;
                        $display("FAIL pulse_match: got ch%0d rise=%0b at cycle %0d, required ch%0d rise=%0b in [%0d,%0d]",
                                 ch, rise[ch], cyc, e.ch, e.is_rise, e.lo, e.hi);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bt_in = 4'hF;
        repeat (8) begin
            step();
            n_cmp++;
            if ({level, rise, fall, any_level} !== 13'b0) begin
                n_err++;
                $display("FAIL reset_outputs: level=%h rise=%h fall=%h any=%b, required all 0", level, rise, fall, any_level);
            end
        end
        bt_in = 4'h0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_clean_press();
        int t0 = cyc;
        bt_in[0] = 1'b1;
        exp_q.push_back('{0, 1'b1, t0 + LO + S, t0 + HI + S});
        for (int k = 0; k < 20 && level[0] !== 1'b1; k++) step();
        n_cmp++;
        if (level[0] !== 1'b1 || cyc - t0 < LO + S || cyc - t0 > HI + S) begin
            n_err++;
            $display("FAIL press_latency: level0=%b after %0d cycles, required 1 within [%0d,%0d]", level[0], cyc - t0, LO + S, HI + S);
        end
        n_cmp++;
        if (any_level !== 1'b0) begin
            n_err++;
            $display("FAIL any_lag: any_level=%b in level update cycle, required 0", any_level);
        end
        step();
        n_cmp++;
        if (any_level !== 1'b1) begin
            n_err++;
            $display("FAIL any_level: any_level=%b one cycle after level, required 1", any_level);
        end
        repeat (6) step();
        n_cmp++;
        if (exp_q.size() != 0 || level !== 4'b0001) begin
            n_err++;
            $display("FAIL press_final: pending=%0d level=%h, required 0 and 1", exp_q.size(), level);
        end
    endtask

    task automatic test_bounce();
        int t0;
        for (int k = 0; k < 8; k++) begin
            bt_in[1] = ~bt_in[1];
            repeat (5) step();
        end
        n_cmp++;
        if (level[1] !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_hold: level1=%b after bouncing, required 0", level[1]);
        end
        bt_in[1] = 1'b1;
        t0 = cyc;
        exp_q.push_back('{1, 1'b1, t0 + LO + S, t0 + HI + S});
        for (int k = 0; k < 20 && level[1] !== 1'b1; k++) step();
        n_cmp++;
        if (level[1] !== 1'b1 || cyc - t0 > HI + S) begin
            n_err++;
            $display("FAIL bounce_settle: level1=%b after %0d cycles, required 1 within %0d", level[1], cyc - t0, HI + S);
        end
        repeat (6) step();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bounce_pending: %0d expected pulses unseen, required 0", exp_q.size());
        end
    endtask

    task automatic test_release_all();
        int t0 = cyc;
        bt_in = 4'hF;
        exp_q.push_back('{2, 1'b1, t0 + LO + S, t0 + HI + S});
        exp_q.push_back('{3, 1'b1, t0 + LO + S, t0 + HI + S});
        for (int k = 0; k < 20 && level !== 4'hF; k++) step();
        n_cmp++;
        if (level !== 4'hF) begin
            n_err++;
            $display("FAIL all_high: level=%h, required F", level);
        end
        repeat (3) step();
        for (int k = 0; k < 4; k++) fall_cyc[k] = -1 - k;
        bt_in = 4'h0;
        t0 = cyc;
        for (int k = 0; k < 4; k++) exp_q.push_back('{k, 1'b0, t0 + LO + S, t0 + HI + S});
        for (int k = 0; k < 20 && level !== 4'h0; k++) step();
        n_cmp++;
        if (level !== 4'h0) begin
            n_err++;
            $display("FAIL release_level: level=%h, required 0", level);
        end
        for (int k = 1; k < 4; k++) begin
            n_cmp++;
            if (fall_cyc[k] != fall_cyc[0]) begin
                n_err++;
                $display("FAIL fall_simul ch%0d: fall at cycle %0d, required %0d (ch0)", k, fall_cyc[k], fall_cyc[0]);
            end
        end
        step();
        n_cmp++;
        if (any_level !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL release_final: any_level=%b pending=%0d, required 0 and 0", any_level, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_count();
        int r;
        bt_in[2] = 1'b1;
        repeat (8) step();
        rst_n = 1'b0;
        repeat (3) begin
            step();
            n_cmp++;
            if (level !== 4'h0 || rise !== 4'h0) begin
                n_err++;
                $display("FAIL midrst_outputs: level=%h rise=%h, required 0 and 0", level, rise);
            end
        end
        rst_n = 1'b1;
        r = cyc;
        exp_q.push_back('{2, 1'b1, r + 12, r + 12});
        repeat (8) begin
            step();
            n_cmp++;
            if (level[2] !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_hold: level2=%b at %0d cycles after release, required 0", level[2], cyc - r);
            end
        end
        for (int k = 0; k < 10 && level[2] !== 1'b1; k++) step();
        n_cmp++;
        if (level[2] !== 1'b1 || cyc - r != 12) begin
            n_err++;
            $display("FAIL midrst_rise: level2=%b after %0d cycles, required 1 after 12", level[2], cyc - r);
        end
        repeat (6) step();
        n_cmp++;
        if (exp_q.size() != 0 || level !== 4'b0100) begin
            n_err++;
            $display("FAIL midrst_final: pending=%0d level=%h, required 0 and 4", exp_q.size(), level);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_all();
        test_reset_mid_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
